// File: rtl/line_fifo.sv
// Circular-buffer FIFO for pixel streams between filter stages (e.g. one image line ahead of a 3x3 window).
// Read latency: 1 cycle registered read by default; first-word fall-through when LINE_FIFO_FWFT_EN is defined.
// Backpressure: writes to a full FIFO and reads from an empty one are dropped and set sticky ovf/udf; a full FIFO accepts a write alongside a read.
module line_fifo #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 98,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int LW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [WIDTH-1:0] d,
  input  logic             rd,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [LW-1:0]    level,
  output logic             ovf,
  output logic             udf
);

  // Pointer width covers DEPTH entries; DEPTH need not be a power of two,
  // so pointers wrap by explicit compare against the last index.
  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_MAX = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF  = LW'(AF_LEVEL);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0]    wptr, rptr;
  logic [PW-1:0]    wptr_nxt, rptr_nxt;
  logic [LW-1:0]    level_r, level_nxt;
  logic             empty_r, full_r, af_r;
  logic             ovf_r, udf_r;
  logic [WIDTH-1:0] q_r;

  logic             rd_ok, wr_ok;
  logic             do_rd, do_wr;

  // Accept decisions use pre-edge status; clr suppresses both operations.
  always_comb begin
    rd_ok     = rd & ~empty_r;
    wr_ok     = wr & (~full_r | rd_ok);
    do_rd     = rd_ok & ~clr;
    do_wr     = wr_ok & ~clr;
    wptr_nxt  = wptr;
    rptr_nxt  = rptr;
    level_nxt = level_r;
    if (clr) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      level_nxt = '0;
    end else begin
      if (do_wr) wptr_nxt = ptr_inc(wptr);
      if (do_rd) rptr_nxt = ptr_inc(rptr);
      if (do_wr && !do_rd)      level_nxt = level_r + 1'b1;
      else if (do_rd && !do_wr) level_nxt = level_r - 1'b1;
    end
  end

  // Pointers, occupancy and status flags; status derives from the next level
  // so it is registered yet always consistent with level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level_r <= '0;
      empty_r <= 1'b1;
      full_r  <= 1'b0;
      af_r    <= 1'b0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      level_r <= level_nxt;
      empty_r <= (level_nxt == '0);
      full_r  <= (level_nxt == LVL_MAX);
      af_r    <= (level_nxt >= LVL_AF);
      if (clr) begin
        ovf_r <= 1'b0;
        udf_r <= 1'b0;
      end else begin
        ovf_r <= ovf_r | (wr & ~wr_ok);
        udf_r <= udf_r | (rd & ~rd_ok);
      end
    end
  end

  // Storage has no reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= d;
  end

`ifdef LINE_FIFO_FWFT_EN
  // Head word after this edge: if the slot being written becomes the head
  // (write into empty, or read+write at level 1) forward d, else read storage.
  logic [WIDTH-1:0] head_nxt;

  always_comb begin
    head_nxt = mem[rptr_nxt];
    if (do_wr && (wptr == rptr_nxt)) head_nxt = d;
  end

  // Output register tracks the head whenever data remains; holds when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= '0;
    end else if (level_nxt != '0) begin
      q_r <= head_nxt;
    end
  end

  assign q_valid = ~empty_r;
`else
  logic qv_r;

  // Registered read: q updates only on an accepted pop, q_valid pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r  <= '0;
      qv_r <= 1'b0;
    end else begin
      qv_r <= do_rd;
      if (do_rd) q_r <= mem[rptr];
    end
  end

  assign q_valid = qv_r;
`endif

  assign q           = q_r;
  assign empty       = empty_r;
  assign full        = full_r;
  assign almost_full = af_r;
  assign level       = level_r;
  assign ovf         = ovf_r;
  assign udf         = udf_r;

endmodule

// File: tb/tb_line_fifo.sv
// Directed bench for line_fifo at WIDTH=8, DEPTH=98.
// Expected values are hand-derived from the write order and counts.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_line_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 98;
  localparam int LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr, wr, rd;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             q_valid, empty, full, almost_full, ovf, udf;
  logic [LW-1:0]    level;

  int n_tests = 0;
  int n_fail  = 0;

  line_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .d(d), .rd(rd),
    .q(q), .q_valid(q_valid), .empty(empty), .full(full),
    .almost_full(almost_full), .level(level), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; d = '0;
    #22;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_af", almost_full, 0);
    check("rst_level", level, 0);
    check("rst_q", q, 0);
    check("rst_qv", q_valid, 0);
    check("rst_ovf", ovf, 0);
    check("rst_udf", udf, 0);
    rst_n = 1'b1;
    tick();

`ifdef LINE_FIFO_FWFT_EN
    // Fall-through: a word written into an empty FIFO is visible next cycle.
    wr = 1'b1; d = 8'h33;
    tick();
    wr = 1'b0;
    check("fwft_q", q, 8'h33);
    check("fwft_qv", q_valid, 1);
    check("fwft_level", level, 1);
    tick();
    check("fwft_hold_q", q, 8'h33);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("fwft_pop_qv", q_valid, 0);
    check("fwft_pop_empty", empty, 1);
    check("fwft_pop_q", q, 8'h33);
    wr = 1'b1; d = 8'h41;
    tick();
    d = 8'h42;
    tick();
    wr = 1'b0;
    check("fwft_head1", q, 8'h41);
    rd = 1'b1;
    tick();
    check("fwft_head2", q, 8'h42);
    check("fwft_head2_qv", q_valid, 1);
    tick();
    rd = 1'b0;
    check("fwft_drain_empty", empty, 1);
    check("fwft_drain_q", q, 8'h42);
`else
    // Fill to full; almost_full rises at level 96.
    for (int i = 1; i <= DEPTH; i++) begin
      wr = 1'b1; d = 8'(i);
      tick();
      check("fill_level", level, i);
      check("fill_af", almost_full, (i >= 96) ? 1 : 0);
      check("fill_full", full, (i == DEPTH) ? 1 : 0);
    end
    d = 8'hEE;
    tick();
    wr = 1'b0;
    check("ovf_set", ovf, 1);
    check("ovf_level", level, DEPTH);
    check("ovf_full", full, 1);

    // Drain: words come out in order, one cycle after each accepted read.
    rd = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      check("drain_q", q, i);
      check("drain_qv", q_valid, 1);
    end
    check("drain_empty", empty, 1);
    check("drain_level", level, 0);
    tick();
    rd = 1'b0;
    check("udf_set", udf, 1);
    check("udf_q_hold", q, 8'h62);
    check("udf_qv", q_valid, 0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf", ovf, 0);
    check("clr_udf", udf, 0);

    // Full FIFO with simultaneous read and write.
    wr = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      d = 8'(i);
      tick();
    end
    rd = 1'b1; d = 8'hAA;
    tick();
    wr = 1'b0;
    check("rw_full_level", level, DEPTH);
    check("rw_full_full", full, 1);
    check("rw_full_ovf", ovf, 0);
    check("rw_full_q", q, 1);
    for (int i = 2; i <= DEPTH; i++) begin
      tick();
      check("rw_drain_q", q, i);
    end
    tick();
    rd = 1'b0;
    check("rw_last_aa", q, 8'hAA);
    check("rw_last_empty", empty, 1);

    // Streaming at level 5 for 300 cycles; pointers wrap several times.
    wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'(i);
      tick();
    end
    rd = 1'b1;
    for (int c = 0; c < 300; c++) begin
      d = 8'(c + 5);
      tick();
      check("stream_q", q, (c & 8'hFF));
      check("stream_level", level, 5);
      check("stream_qv", q_valid, 1);
    end
    wr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stream_tail_q", q, ((300 + i) & 8'hFF));
    end
    rd = 1'b0;
    check("stream_empty", empty, 1);
    check("stream_udf", udf, 0);

    // Reach level 10 with ovf set, then clr alongside a write.
    wr = 1'b1;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      d = (i <= DEPTH) ? 8'(i) : 8'hEE;
      tick();
    end
    wr = 1'b0; rd = 1'b1;
    for (int i = 1; i <= 88; i++) begin
      tick();
    end
    rd = 1'b0;
    check("pre_clr_level", level, 10);
    check("pre_clr_ovf", ovf, 1);
    check("pre_clr_q", q, 88);
    clr = 1'b1; wr = 1'b1; d = 8'h55;
    tick();
    clr = 1'b0; wr = 1'b0;
    check("clr_level", level, 0);
    check("clr_empty", empty, 1);
    check("clr_ovf2", ovf, 0);
    check("clr_full", full, 0);
    check("clr_qv", q_valid, 0);
    check("clr_q_hold", q, 88);
    tick();
    check("clr_wr_dropped", level, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("clr_rd_udf", udf, 1);
    check("clr_rd_q", q, 88);

    // Asynchronous reset in the middle of a q_valid pulse.
    wr = 1'b1;
    for (int i = 7; i <= 9; i++) begin
      d = 8'(i);
      tick();
    end
    wr = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    check("mid_q", q, 7);
    check("mid_qv", q_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_qv", q_valid, 0);
    check("arst_q", q, 0);
    check("arst_level", level, 0);
    check("arst_empty", empty, 1);
    check("arst_udf", udf, 0);
    #3 rst_n = 1'b1;
    tick();
    check("post_rst_empty", empty, 1);
    check("post_rst_level", level, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/line_fifo.md
Name: line_fifo

Overview:
- Parametrised synchronous FIFO for buffering pixel streams between filter stages, e.g. one image line ahead of a 3x3 kernel window.
- Circular-buffer storage with read/write pointers and an occupancy counter, so no per-entry shifting.
- Provides full, empty, almost-full and level status plus sticky overflow/underflow flags.
- Supports a synchronous flush.

Parameters:
- WIDTH, 8, data width in bits (pixel width).
- DEPTH, 98, number of entries. Any integer >= 2; power of two not required.
- AF_LEVEL, DEPTH-2, level at or above which almost_full asserts.
- LW, $clog2(DEPTH+1), width of the level output (derived; not to be overridden).

Ports:
- clk, in, 1, clock; all state changes on the rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- clr, in, 1, synchronous flush: empties the FIFO and clears the sticky flags.
- wr, in, 1, write request.
- d, in, WIDTH, write data.
- rd, in, 1, read request.
- q, out, WIDTH, read data.
- q_valid, out, 1, q holds newly popped data this cycle.
- empty, out, 1, level == 0.
- full, out, 1, level == DEPTH.
- almost_full, out, 1, level >= AF_LEVEL.
- level, out, LW, current occupancy.
- ovf, out, 1, sticky: a write was rejected.
- udf, out, 1, sticky: a read was rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - wptr = rptr = level = 0.
  - q = 0, q_valid = 0, empty = 1, full = 0, almost_full = 0, ovf = 0, udf = 0.
  - Storage contents are don't-care.
- Accept rules, evaluated on pre-edge state:
  - rd_ok = rd & ~empty.
  - wr_ok = wr & (~full | rd_ok). A write into a full FIFO is accepted when a read is accepted in the same cycle.
  - Simultaneous rd & wr while empty: the write is accepted, the read is rejected (udf set), and the new word is not bypassed to q.
- Write (wr_ok): mem[wptr] <= d; wptr advances. It wraps from DEPTH-1 to 0 by explicit compare, not modulo-2^n.
- Read (rd_ok), default mode:
  - q <= mem[rptr]; rptr advances with the same wrap rule. Read latency is 1 cycle.
  - q_valid pulses high for exactly the cycle after an accepted read.
  - q holds its value otherwise.
- Level update:
  - +1 on wr_ok only; -1 on rd_ok only; unchanged on both or neither.
  - Never exceeds DEPTH and never goes below 0.
- Status outputs:
  - empty, full and almost_full are registered, consistent with level in the same cycle, and exclude rejected operations.
- Errors:
  - ovf set on wr & ~wr_ok; udf set on rd & ~rd_ok.
  - Both hold until clr or reset. A rejected write leaves storage untouched.
- clr:
  - Overrides wr and rd in the same cycle.
  - Pointers and level go to 0; empty = 1, full = 0, almost_full = 0, ovf = udf = 0, q_valid = 0.
  - q holds its value.
- Reset mid-operation: any in-flight q_valid pulse is cancelled immediately; the FIFO is empty once reset releases.
- Order: data exits in strict write order across any number of pointer wraps.

Optional Feature:
- Macro: LINE_FIFO_FWFT_EN.
- Defined (first-word fall-through):
  - q always presents mem[rptr] when not empty, and q_valid = ~empty (level-based, not a pulse).
  - rd acts as acknowledge: it pops the current word and the next word appears on q the following cycle.
  - A word written into an empty FIFO appears on q one cycle after the write edge, with q_valid high.
  - When empty, q holds its last value.
- Undefined: default registered-read behaviour above, 1-cycle latency.

Test Plan:
- Reset, then write 0x01..0x62 (98 words) with rd=0 -> full=1 and level=98 after the last write; almost_full first rises at level 96. One extra write sets ovf=1 and leaves the contents unchanged.
- Read all 98 words -> q sequence 0x01..0x62 with q_valid one cycle after each rd. empty=1 after the last read; one extra rd sets udf=1 and q stays 0x62.
- While full, assert rd=1, wr=1, d=0xAA for one cycle -> level stays 98, full stays 1, ovf stays 0. After draining, 0xAA is the final word out.
- Run continuous streaming rd+wr for 300 cycles at level 5 (DEPTH=98) -> pointers wrap at least 3 times; output equals input delayed by 5 entries; level is constant at 5.
- Write 10 words with ovf set, then pulse clr concurrently with wr=1 -> level=0, empty=1, ovf=0, and the concurrent write is discarded. Assert rst_n=0 mid-stream -> all outputs return to reset values asynchronously, before the next clock edge.
- With LINE_FIFO_FWFT_EN defined: write 0x33 into an empty FIFO -> q=0x33 and q_valid=1 on the next cycle without rd. rd for one cycle -> q_valid=0 and empty=1.
